// File: rtl/konwersja_pkg.sv
// konwersja_pkg: shared types and constants for the sign-magnitude to U2 converter
package konwersja_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/konw_neg_bit.sv
// konw_neg_bit: one step of serial two's-complement negation (copy through first 1, invert after)
module konw_neg_bit (
  input  logic m,
  input  logic sign,
  input  logic found_one,
  output logic out_bit,
  output logic found_one_next
);
  assign out_bit        = m ^ (sign & found_one);
  assign found_one_next = found_one | (sign & m);
endmodule

// File: rtl/konwersja_odwrotna.sv
// konwersja_odwrotna: bit-serial sign-magnitude to U2 converter with valid/ready on both sides
module konwersja_odwrotna
  import konwersja_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_argA,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error,
  output logic             o_valid,
  input  logic             i_ready
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_n;
  logic sign, found_one, nonzero, out_bit, found_one_next, last;
  logic [WIDTH-2:0] mag, res;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0] cnt;
  konw_neg_bit u_neg (
    .m(mag[0]), .sign(sign), .found_one(found_one),
    .out_bit(out_bit), .found_one_next(found_one_next)
  );
  assign last    = cnt == CW'(WIDTH - 2);
  assign res_sh  = {out_bit, res} >> 1;
  assign o_ready = state == IDLE;
  // DONE spends its first cycle registering the result, giving a WIDTH-edge latency
  always_comb begin
    state_n = (state == IDLE && i_valid) ? SHIFT :
              (state == SHIFT && last) ? DONE :
              (state == DONE && o_valid && i_ready) ? IDLE : state;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      found_one <= 1'b0;
      nonzero   <= 1'b0;
      mag       <= '0;
      res       <= '0;
      cnt       <= '0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_error   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && i_valid) begin
        sign      <= i_argA[WIDTH-1];
        mag       <= i_argA[WIDTH-2:0];
        cnt       <= '0;
        found_one <= 1'b0;
        nonzero   <= 1'b0;
      end
      if (state == SHIFT) begin
        mag       <= mag >> 1;
        res       <= res_sh[WIDTH-2:0];
        found_one <= found_one_next;
        nonzero   <= nonzero | mag[0];
        cnt       <= cnt + 1'b1;
      end
      if (state == DONE && !o_valid) begin
        o_valid  <= 1'b1;
        o_result <= {sign & nonzero, res};
        o_error  <= sign & ~nonzero;
      end
      if (state == DONE && o_valid && i_ready) o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_konwersja_odwrotna.sv
// tb_konwersja_odwrotna: directed checks of the serial converter at WIDTH=8 and WIDTH=32
module tb_konwersja_odwrotna;
  logic clk = 0, rst = 1;
  logic [7:0] arg8 = '0, res8;
  logic val8 = 0, rdy8 = 1, ordy8, ov8, err8;
  logic [31:0] arg32 = '0, res32;
  logic val32 = 0, ordy32, ov32, err32;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  konwersja_odwrotna #(.WIDTH(8)) d8 (
    .i_clk(clk), .i_rst(rst), .i_argA(arg8), .i_valid(val8), .o_ready(ordy8),
    .o_result(res8), .o_error(err8), .o_valid(ov8), .i_ready(rdy8)
  );
  konwersja_odwrotna #(.WIDTH(32)) d32 (
    .i_clk(clk), .i_rst(rst), .i_argA(arg32), .i_valid(val32), .o_ready(ordy32),
    .o_result(res32), .o_error(err32), .o_valid(ov32), .i_ready(1'b1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] er, input logic ee);
    int n;
    @(negedge clk);
    check({tag, "_rdy_in"}, ordy8, 1);
    arg8 = a;
    val8 = 1;
    @(posedge clk);
    #1 val8 = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!ov8 && n < 40);
    check({tag, "_lat"}, n, 8);
    check({tag, "_res"}, res8, er);
    check({tag, "_err"}, err8, ee);
    @(posedge clk);
    #1 check({tag, "_rdy_out"}, ordy8, 1);
    check({tag, "_vld_out"}, ov8, 0);
  endtask
  initial begin
    int n;
    #3;
    check("rst_rdy", ordy8, 1);
    check("rst_vld", ov8, 0);
    check("rst_res", res8, 0);
    check("rst_err", err8, 0);
    @(negedge clk) rst = 0;
    run8("neg5", 8'h85, 8'hFB, 0);
    run8("pos5", 8'h05, 8'h05, 0);
    run8("pos127", 8'h7F, 8'h7F, 0);
    run8("neg127", 8'hFF, 8'h81, 0);
    run8("neg1", 8'h81, 8'hFF, 0);
    run8("negzero", 8'h80, 8'h00, 1);
    run8("poszero", 8'h00, 8'h00, 0);
    // backpressure: hold i_ready low with a competing operand offered
    @(negedge clk);
    rdy8 = 0;
    arg8 = 8'h81;
    val8 = 1;
    @(posedge clk);
    #1 val8 = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!ov8 && n < 40);
    check("bp_lat", n, 8);
    arg8 = 8'h05;
    val8 = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("bp_vld", ov8, 1);
      check("bp_res", res8, 8'hFF);
      check("bp_rdy", ordy8, 0);
    end
    @(negedge clk);
    val8 = 0;
    rdy8 = 1;
    @(posedge clk);
    #1 check("bp_rel_rdy", ordy8, 1);
    check("bp_rel_vld", ov8, 0);
    // reset while shifting
    @(negedge clk);
    arg8 = 8'h85;
    val8 = 1;
    @(posedge clk);
    #1 val8 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 check("mid_rst_vld", ov8, 0);
    check("mid_rst_rdy", ordy8, 1);
    check("mid_rst_res", res8, 0);
    @(negedge clk) rst = 0;
    run8("after_rst", 8'h83, 8'hFD, 0);
    // WIDTH=32 spot check
    @(negedge clk);
    arg32 = 32'h8000_0001;
    val32 = 1;
    @(posedge clk);
    #1 val32 = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!ov32 && n < 80);
    check("w32_lat", n, 32);
    check("w32_res", res32, 32'hFFFF_FFFF);
    check("w32_err", err32, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
